// File: rtl/bp_fe_ras_ctrl_pkg.sv
// ============================================================================
// Module      : bp_fe_ras_ctrl_pkg
// Description : Shared front-end definitions for return-address-stack control:
//               instruction classes, FSM states, opcodes, link-register test.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_fe_ras_ctrl_pkg;

  typedef enum logic [1:0] {
    CLASS_NONE = 2'd0,
    CLASS_CALL = 2'd1,
    CLASS_RET  = 2'd2,
    CLASS_SWAP = 2'd3
  } ras_class_e;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_SWAP_PUSH = 1'b1
  } ras_state_e;

  localparam logic [6:0] c_opcode_jal   = 7'b1101111;
  localparam logic [6:0] c_opcode_jalr  = 7'b1100111;
  localparam logic [2:0] c_funct3_jalr  = 3'b000;

  // x1 (ra) and x5 (t0) are the architectural link registers
  function automatic logic is_link_reg(input logic [4:0] reg_idx);
    return (reg_idx == 5'd1) || (reg_idx == 5'd5);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_fe_ras_predecode.sv
// ============================================================================
// Module      : bp_fe_ras_predecode
// Description : Combinational call/return/swap classifier for one 32-bit
//               RISC-V instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_fe_ras_predecode
  import bp_fe_ras_ctrl_pkg::*;
#(
  parameter int instr_width_p = 32
) (
  input  logic [instr_width_p-1:0] instr_i,
  output logic [1:0]               class_o
);

  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [2:0] w_funct3;
  logic       w_rd_link;
  logic       w_rs1_link;
  ras_class_e w_class;
  logic       w_unused_bits;

  assign w_opcode      = instr_i[6:0];
  assign w_rd          = instr_i[11:7];
  assign w_funct3      = instr_i[14:12];
  assign w_rs1         = instr_i[19:15];
  assign w_rd_link     = is_link_reg(w_rd);
  assign w_rs1_link    = is_link_reg(w_rs1);
  assign w_unused_bits = ^instr_i[instr_width_p-1:20];

  always_comb begin
    w_class = CLASS_NONE;
    if (w_opcode == c_opcode_jal) begin
      if (w_rd_link) begin
        w_class = CLASS_CALL;
      end
    end else if ((w_opcode == c_opcode_jalr) && (w_funct3 == c_funct3_jalr)) begin
      case ({w_rd_link, w_rs1_link})
        2'b10:   w_class = CLASS_CALL;
        2'b01:   w_class = CLASS_RET;
        // Same link register on both sides is a plain call; different ones swap
        2'b11:   w_class = (w_rd == w_rs1) ? CLASS_CALL : CLASS_SWAP;
        default: w_class = CLASS_NONE;
      endcase
    end
  end

  assign class_o = w_class;

endmodule

`default_nettype wire

// File: rtl/bp_fe_ras_ctrl.sv
// ============================================================================
// Module      : bp_fe_ras_ctrl
// Description : Drives RAS push/pop strobes and return-target prediction from
//               fetched instructions, with a saturating occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_fe_ras_ctrl
  import bp_fe_ras_ctrl_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int ras_els_p     = 8,
  parameter int instr_width_p = 32
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             fetch_v_i,
  output logic                             fetch_ready_o,
  input  logic [vaddr_width_p-1:0]         fetch_pc_i,
  input  logic [instr_width_p-1:0]         fetch_instr_i,
  input  logic                             redirect_v_i,
  input  logic [vaddr_width_p-1:0]         ras_top_i,
  output logic                             is_call_o,
  output logic                             ovr_ret_o,
  output logic [vaddr_width_p-1:0]         return_addr_o,
  output logic                             pred_v_o,
  output logic [vaddr_width_p-1:0]         pred_addr_o,
  output logic [$clog2(ras_els_p+1)-1:0]   depth_o
);

  localparam int                   c_depth_w   = $clog2(ras_els_p + 1);
  localparam logic [c_depth_w-1:0] c_depth_max = c_depth_w'(ras_els_p);

  logic                     r_stage_v;
  logic [vaddr_width_p-1:0] r_stage_pc;
  ras_class_e               r_stage_class;
  ras_state_e               r_state;
  ras_state_e               w_state_next;
  logic [c_depth_w-1:0]     r_depth;
  logic [c_depth_w-1:0]     w_depth_next;

  logic [1:0]               w_fetch_class;
  logic                     w_accept;
  logic                     w_stage_swap;
  logic [vaddr_width_p-1:0] w_push_addr;

  bp_fe_ras_predecode #(
    .instr_width_p (instr_width_p)
  ) u_predecode (
    .instr_i (fetch_instr_i),
    .class_o (w_fetch_class)
  );

  assign w_stage_swap  = r_stage_v && (r_stage_class == CLASS_SWAP);
  assign fetch_ready_o = (r_state != ST_SWAP_PUSH) && !w_stage_swap && !redirect_v_i;
  assign w_accept      = fetch_v_i && fetch_ready_o;
  // Stage pc is frozen while a swap is in flight, so it doubles as the held push pc
  assign w_push_addr   = r_stage_pc + vaddr_width_p'(4);

  always_comb begin
    is_call_o     = 1'b0;
    ovr_ret_o     = 1'b0;
    return_addr_o = '0;
    pred_v_o      = 1'b0;
    pred_addr_o   = '0;
    w_state_next  = ST_IDLE;

    if (!redirect_v_i) begin
      if (r_state == ST_SWAP_PUSH) begin
        is_call_o     = 1'b1;
        return_addr_o = w_push_addr;
      end else if (r_stage_v) begin
        case (r_stage_class)
          CLASS_CALL: begin
            is_call_o     = 1'b1;
            return_addr_o = w_push_addr;
          end
          CLASS_RET, CLASS_SWAP: begin
            if (r_depth != '0) begin
              ovr_ret_o   = 1'b1;
              pred_v_o    = 1'b1;
              pred_addr_o = ras_top_i;
            end
            if (r_stage_class == CLASS_SWAP) begin
              w_state_next = ST_SWAP_PUSH;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Saturation leaves depth at the limit; the RAS itself overwrites its oldest entry
  always_comb begin
    w_depth_next = r_depth;
    if (is_call_o) begin
      if (r_depth != c_depth_max) begin
        w_depth_next = r_depth + c_depth_w'(1);
      end
    end else if (ovr_ret_o) begin
      w_depth_next = r_depth - c_depth_w'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_depth <= '0;
    end else begin
      r_state <= w_state_next;
      r_depth <= w_depth_next;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stage_v     <= 1'b0;
      r_stage_pc    <= '0;
      r_stage_class <= CLASS_NONE;
    end else begin
      r_stage_v <= w_accept;
      if (w_accept) begin
        r_stage_pc    <= fetch_pc_i;
        r_stage_class <= ras_class_e'(w_fetch_class);
      end
    end
  end

  assign depth_o = r_depth;

endmodule

`default_nettype wire
